// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Grants whole packets, split after MAX_BURST beats when MAX_BURST is nonzero.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int SRC_W     = $clog2(NREQ)
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   full,
  output logic                   wr_en,
  output logic [DATA_W-1:0]      wr_data,
  output logic [SRC_W-1:0]       wr_src,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int CNT_W     = (MAX_BURST <= 2) ? 1 : $clog2(MAX_BURST);
  localparam int BURST_LIM = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t             r_state;
  logic [NREQ-1:0]    r_grant;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic               w_pick_found;
  logic [SRC_W-1:0]   w_pick_idx;
  logic               w_own_valid;
  logic               w_own_last;
  logic [DATA_W-1:0]  w_own_data;
  logic               w_rdy;
  logic               w_accept;
  logic               w_burst_end;
  logic               w_release;
  logic [SRC_W-1:0]   w_next_ptr;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int k;
    k            = 0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!w_pick_found && req_valid[k]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = SRC_W'(k);
      end
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_src == SRC_W'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_rdy       = (r_state == S_XFER) & ~full & ~rst;
  assign w_accept    = w_rdy & w_own_valid;
  assign w_burst_end = (MAX_BURST != 0) && (r_beat_cnt == CNT_W'(BURST_LIM));
  assign w_release   = w_accept & (w_own_last | w_burst_end);
  assign w_next_ptr  = (r_src == SRC_W'(NREQ - 1)) ? '0 : r_src + 1'b1;

  assign req_ready = w_rdy ? r_grant : '0;
  assign wr_en     = w_accept;
  assign wr_data   = w_own_data;
  assign wr_src    = r_src;
  assign grant     = r_grant;
  assign busy      = (r_state == S_XFER);

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_src      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            r_state    <= S_XFER;
            r_grant    <= NREQ'(1) << w_pick_idx;
            r_src      <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        S_XFER: begin
          if (w_release) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= w_next_ptr;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (MAX_BURST=4) with per-requester beat
// queues, a write log, and hand-computed expected write sequences.
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int MB     = 4;
  localparam int SRC_W  = 2;

  logic                   wr_clk = 1'b0;
  logic                   rst    = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DATA_W-1:0] req_data  = '0;
  logic [NREQ-1:0]        req_last  = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   full = 1'b0;
  logic                   wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic [SRC_W-1:0]       wr_src;
  logic [NREQ-1:0]        grant;
  logic                   busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(MB), .SRC_W(SRC_W)) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full(full), .wr_en(wr_en),
    .wr_data(wr_data), .wr_src(wr_src), .grant(grant), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 wr_clk = ~wr_clk;

  // ---------------- requester queues and logs ----------------
  logic [8:0] src_mem [NREQ][16];
  int         src_head [NREQ];
  int         src_tail [NREQ];
  int         full_lo, full_hi, rst_cyc;

  logic             busy_l  [64];
  logic             wr_en_l [64];
  logic [NREQ-1:0]  grant_l [64];
  logic [NREQ-1:0]  ready_l [64];
  logic [SRC_W-1:0] src_l   [64];

  logic [SRC_W+DATA_W-1:0] got_q[$];
  int                      got_cyc[$];
  logic [SRC_W+DATA_W-1:0] exp_q[$];
  int                      exp_cyc[$];

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
    full_lo = -1; full_hi = -1; rst_cyc = -1;
  endtask

  task automatic push_beat(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_tail[r]] = {l, d};
    src_tail[r]++;
  endtask

  task automatic expect_wr(input int s, input logic [7:0] d, input int c);
    exp_q.push_back({SRC_W'(s), d});
    exp_cyc.push_back(c);
  endtask

  // Drives one cycle per iteration; samples mid-cycle, advances queues after the edge.
  task automatic run(input int ncyc);
    logic [NREQ-1:0] hs;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (src_head[i] < src_tail[i]);
        req_data[i*DATA_W +: DATA_W] = req_valid[i] ? src_mem[i][src_head[i]][7:0] : 8'h00;
        req_last[i] = req_valid[i] ? src_mem[i][src_head[i]][8] : 1'b0;
      end
      full = (c >= full_lo) && (c <= full_hi);
      rst  = (c == rst_cyc);
      #2;
      busy_l[c] = busy; wr_en_l[c] = wr_en; grant_l[c] = grant;
      ready_l[c] = req_ready; src_l[c] = wr_src;
      checks++;
      if (wr_en && (full || rst)) begin
        errors++;
        $display("FAIL wr_guard cyc=%0d wr_en=%b full=%b rst=%b required wr_en=0", c, wr_en, full, rst);
      end
      checks++;
      if ((req_ready & ~grant) !== '0) begin
        errors++;
        $display("FAIL ready_owner cyc=%0d req_ready=%b grant=%b required ready only to owner", c, req_ready, grant);
      end
      if (wr_en) begin
        got_q.push_back({wr_src, wr_data});
        got_cyc.push_back(c);
      end
      hs = req_valid & req_ready;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) src_head[i]++;
    end
    rst = 1'b0;
  endtask

  // ---------------- scoreboard comparisons per test ----------------
  task automatic test_reset();
    clear_all();
    rst = 1'b1;
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    checks++;
    if (wr_en !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_outputs wr_en=%b req_ready=%b required 0/0", wr_en, req_ready);
    end
    run(10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (grant_l[c] !== '0 || wr_en_l[c] !== 1'b0 || busy_l[c] !== 1'b0 || ready_l[c] !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d grant=%b wr_en=%b busy=%b ready=%b required all 0",
                 c, grant_l[c], wr_en_l[c], busy_l[c], ready_l[c]);
      end
    end
    checks++;
    if (src_l[0] !== '0) begin
      errors++;
      $display("FAIL reset_src wr_src=%0d required 0", src_l[0]);
    end
  endtask

  task automatic test_round_robin();
    clear_all();
    for (int i = 0; i < NREQ; i++) push_beat(i, 8'hA0 + 8'(i), 1'b1);
    expect_wr(0, 8'hA0, 1); expect_wr(1, 8'hA1, 3);
    expect_wr(2, 8'hA2, 5); expect_wr(3, 8'hA3, 7);
    run(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rr_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL rr_write[%0d] got=%h@%0d required=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    checks++;
    if (busy_l[0] !== 1'b0 || busy_l[1] !== 1'b1 || grant_l[1] !== 4'b0001) begin
      errors++;
      $display("FAIL rr_latency busy0=%b busy1=%b grant1=%b required 0/1/0001", busy_l[0], busy_l[1], grant_l[1]);
    end
  endtask

  task automatic test_packet();
    clear_all();
    push_beat(1, 8'h11, 1'b0); push_beat(1, 8'h12, 1'b0); push_beat(1, 8'h13, 1'b1);
    push_beat(2, 8'h21, 1'b1);
    expect_wr(1, 8'h11, 1); expect_wr(1, 8'h12, 2); expect_wr(1, 8'h13, 3);
    expect_wr(2, 8'h21, 5);
    run(8);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL pkt_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL pkt_write[%0d] got=%h@%0d required=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (ready_l[c][2] !== 1'b0) begin
        errors++;
        $display("FAIL pkt_req2_ready cyc=%0d ready=%b required 0", c, ready_l[c][2]);
      end
    end
    checks++;
    if (busy_l[4] !== 1'b0 || grant_l[4] !== '0) begin
      errors++;
      $display("FAIL pkt_gap busy=%b grant=%b required 0/0000", busy_l[4], grant_l[4]);
    end
  endtask

  task automatic test_full();
    clear_all();
    push_beat(3, 8'h31, 1'b0); push_beat(3, 8'h32, 1'b0);
    push_beat(3, 8'h33, 1'b0); push_beat(3, 8'h34, 1'b1);
    full_lo = 3; full_hi = 7;
    expect_wr(3, 8'h31, 1); expect_wr(3, 8'h32, 2);
    expect_wr(3, 8'h33, 8); expect_wr(3, 8'h34, 9);
    run(12);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL full_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL full_write[%0d] got=%h@%0d required=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    for (int c = 3; c <= 7; c++) begin
      checks++;
      if (ready_l[c] !== '0 || wr_en_l[c] !== 1'b0 || grant_l[c] !== 4'b1000) begin
        errors++;
        $display("FAIL full_hold cyc=%0d ready=%b wr_en=%b grant=%b required 0000/0/1000",
                 c, ready_l[c], wr_en_l[c], grant_l[c]);
      end
    end
  endtask

  task automatic test_max_burst();
    clear_all();
    for (int b = 1; b <= 6; b++) push_beat(0, 8'(b), b == 6);
    push_beat(3, 8'h3A, 1'b0); push_beat(3, 8'h3B, 1'b1);
    expect_wr(0, 8'h01, 1); expect_wr(0, 8'h02, 2); expect_wr(0, 8'h03, 3); expect_wr(0, 8'h04, 4);
    expect_wr(3, 8'h3A, 6); expect_wr(3, 8'h3B, 7);
    expect_wr(0, 8'h05, 9); expect_wr(0, 8'h06, 10);
    run(14);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL burst_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL burst_write[%0d] got=%h@%0d required=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int b = 1; b <= 4; b++) push_beat(2, 8'h40 + 8'(b), b == 4);
    push_beat(0, 8'h50, 1'b1);
    rst_cyc = 2;
    expect_wr(2, 8'h41, 1); expect_wr(0, 8'h50, 4);
    expect_wr(2, 8'h42, 6); expect_wr(2, 8'h43, 7); expect_wr(2, 8'h44, 8);
    run(12);
    checks++;
    if (wr_en_l[2] !== 1'b0 || ready_l[2] !== '0) begin
      errors++;
      $display("FAIL rstmid_block wr_en=%b ready=%b required 0/0000", wr_en_l[2], ready_l[2]);
    end
    checks++;
    if (busy_l[3] !== 1'b0 || grant_l[3] !== '0 || src_l[3] !== '0) begin
      errors++;
      $display("FAIL rstmid_idle busy=%b grant=%b src=%0d required 0/0000/0", busy_l[3], grant_l[3], src_l[3]);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL rstmid_write[%0d] got=%h@%0d required=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_packet();
    test_full();
    test_max_burst();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
